// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Consumes command/data byte pairs from the SPI slave byte receiver, executes
// register writes and preloads the response byte for the next SPI frame.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a command byte
// DATA  | command latched, waiting for its data byte (timeout running)
module spi_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ID_VALUE       = 8'hA5
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [7:0] gpio_in,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [7:0] gpio_out,
    output logic [7:0] mode,
    output logic       soft_rst,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_MODE    = 4'h1;
    localparam logic [3:0] ADDR_GPIO    = 4'h2;
    localparam logic [3:0] ADDR_GPIO_IN = 4'h3;
    localparam logic [3:0] ADDR_ID      = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    cmd_addr;
    logic          cmd_wr;
    logic          cmd_ok;

    logic          rx_mapped;
    logic          rx_ok;
    logic [7:0]    rd_value;
    logic          wr_now;
    logic          timeout_now;
    logic          err_next;

    // Decode the incoming byte as a command: legality and read-back value.
    always_comb begin
        rx_mapped = 1'b0;
        rd_value  = 8'h00;
        case (rx_byte[3:0])
            ADDR_CTRL: begin
                rx_mapped = 1'b1;
                rd_value  = {7'b0, err};
            end
            ADDR_MODE: begin
                rx_mapped = 1'b1;
                rd_value  = mode;
            end
            ADDR_GPIO: begin
                rx_mapped = 1'b1;
                rd_value  = gpio_out;
            end
            ADDR_GPIO_IN: begin
                rx_mapped = 1'b1;
                rd_value  = gpio_in;
            end
            ADDR_ID: begin
                rx_mapped = 1'b1;
                rd_value  = ID_VALUE;
            end
            default: begin
                rx_mapped = 1'b0;
                rd_value  = 8'h00;
            end
        endcase
        // Read-only registers reject writes; the reserved field must be zero.
        rx_ok = rx_mapped && (rx_byte[6:4] == 3'b000) &&
                !(rx_byte[7] && ((rx_byte[3:0] == ADDR_GPIO_IN) ||
                                 (rx_byte[3:0] == ADDR_ID)));
    end

    // Pair completion, timeout detection and the error flag after this edge.
    always_comb begin
        wr_now      = (state == DATA) && rx_valid && cmd_ok && cmd_wr;
        timeout_now = (state == DATA) && !rx_valid && (cnt == CNT_LAST);
        err_next    = err;
        if ((state == IDLE) && rx_valid && !rx_ok) begin
            err_next = 1'b1;
        end else if (timeout_now) begin
            err_next = 1'b1;
        end else if (wr_now && (cmd_addr == ADDR_CTRL) &&
                     (rx_byte[0] || rx_byte[1])) begin
            // Soft reset (bit0) and explicit clear (bit1) both drop err.
            err_next = 1'b0;
        end
    end

    // Command/data FSM with registered outputs and register file.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd_addr <= 4'h0;
            cmd_wr   <= 1'b0;
            cmd_ok   <= 1'b0;
            tx_byte  <= 8'h00;
            tx_load  <= 1'b0;
            gpio_out <= 8'h00;
            mode     <= 8'h00;
            soft_rst <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_load  <= 1'b0;
            soft_rst <= 1'b0;
            err      <= err_next;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cmd_addr <= rx_byte[3:0];
                        cmd_wr   <= rx_byte[7];
                        cmd_ok   <= rx_ok;
                        cnt      <= '0;
                        tx_load  <= 1'b1;
                        tx_byte  <= (rx_ok && !rx_byte[7]) ? rd_value : 8'h00;
                        state    <= DATA;
                        busy     <= 1'b1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        if (wr_now) begin
                            case (cmd_addr)
                                ADDR_CTRL: begin
                                    if (rx_byte[0]) begin
                                        soft_rst <= 1'b1;
                                        mode     <= 8'h00;
                                        gpio_out <= 8'h00;
                                    end
                                end
                                ADDR_MODE: mode     <= rx_byte;
                                ADDR_GPIO: gpio_out <= rx_byte;
                                default: ;
                            endcase
                        end
                        tx_load <= 1'b1;
                        tx_byte <= {7'b0, err_next};
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else if (timeout_now) begin
                        // Abandon the pair silently; framing restarts at IDLE.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder: directed scenarios plus randomized byte
// streams compared against a transaction-level register model.
module tb_spi_cmd_decoder;

    localparam int unsigned TO = 16;
    localparam logic [7:0]  ID = 8'hA5;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [7:0] gpio_out;
    logic [7:0] mode;
    logic       soft_rst;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_mode, m_gpio, m_tx;
    logic       m_err, m_pair, m_ok, m_wr, m_load, m_soft;
    logic [3:0] m_addr;
    int         m_wait;

    spi_cmd_decoder #(.TIMEOUT_CYCLES(TO), .ID_VALUE(ID)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .gpio_in (gpio_in),
        .tx_byte (tx_byte),
        .tx_load (tx_load),
        .gpio_out(gpio_out),
        .mode    (mode),
        .soft_rst(soft_rst),
        .busy    (busy),
        .err     (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 8'h00; m_gpio = 8'h00; m_err = 1'b0; m_pair = 1'b0;
        m_ok = 1'b0; m_wr = 1'b0; m_addr = 4'h0; m_wait = 0; m_tx = 8'h00;
    endtask

    // One received byte, as the register map describes it.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] rv;
        if (!m_pair) begin
            m_addr = b[3:0];
            m_wr   = b[7];
            m_ok   = (b[6:4] == 3'd0) &&
                     (m_addr inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hF}) &&
                     !(m_wr && (m_addr inside {4'h3, 4'hF}));
            case (m_addr)
                4'h0: rv = {7'b0, m_err};
                4'h1: rv = m_mode;
                4'h2: rv = m_gpio;
                4'h3: rv = gpio_in;
                4'hF: rv = ID;
                default: rv = 8'h00;
            endcase
            m_tx = (m_ok && !m_wr) ? rv : 8'h00;
            if (!m_ok) m_err = 1'b1;
            m_pair = 1'b1;
            m_wait = 0;
        end else begin
            if (m_ok && m_wr) begin
                if (m_addr == 4'h0) begin
                    if (b[0]) begin
                        m_soft = 1'b1; m_mode = 8'h00; m_gpio = 8'h00; m_err = 1'b0;
                    end else if (b[1]) begin
                        m_err = 1'b0;
                    end
                end else if (m_addr == 4'h1) begin
                    m_mode = b;
                end else if (m_addr == 4'h2) begin
                    m_gpio = b;
                end
            end
            m_tx = {7'b0, m_err};
            m_pair = 1'b0;
        end
        m_load = 1'b1;
    endtask

    task automatic model_idle();
        if (m_pair) begin
            m_wait++;
            if (m_wait >= TO) begin
                m_pair = 1'b0;
                m_err  = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tx_load"}, {7'b0, tx_load}, {7'b0, m_load});
        if (m_load) chk({tag, ".tx_byte"}, tx_byte, m_tx);
        chk({tag, ".mode"}, mode, m_mode);
        chk({tag, ".gpio_out"}, gpio_out, m_gpio);
        chk({tag, ".err"}, {7'b0, err}, {7'b0, m_err});
        chk({tag, ".busy"}, {7'b0, busy}, {7'b0, m_pair});
        chk({tag, ".soft_rst"}, {7'b0, soft_rst}, {7'b0, m_soft});
    endtask

    // One clock cycle with or without a received byte, then compare.
    task automatic step(input logic v, input logic [7:0] b, input string tag);
        @(negedge sys_clk);
        rx_valid = v;
        rx_byte  = v ? b : 8'h00;
        @(posedge sys_clk);
        #1;
        m_load = 1'b0;
        m_soft = 1'b0;
        if (v) model_byte(b);
        else   model_idle();
        check_all(tag);
    endtask

    task automatic pair(input logic [7:0] c, input logic [7:0] d, input string tag);
        step(1'b1, c, {tag, ".cmd"});
        step(1'b1, d, {tag, ".dat"});
        step(1'b0, 8'h00, {tag, ".gap"});
    endtask

    task automatic do_reset(input string tag);
        @(negedge sys_clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        model_reset();
        m_load = 1'b0;
        m_soft = 1'b0;
        check_all(tag);
        chk({tag, ".tx_byte"}, tx_byte, 8'h00);
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        m_load = 1'b0;
        m_soft = 1'b0;
        repeat (2) @(posedge sys_clk);
        do_reset("reset");

        // Write MODE
        pair(8'h81, 8'h3C, "wr_mode");
        chk("wr_mode.value", mode, 8'h3C);

        // Write then read GPIO_OUT
        pair(8'h82, 8'hAA, "wr_gpio");
        step(1'b1, 8'h02, "rd_gpio.cmd");
        chk("rd_gpio.value", tx_byte, 8'hAA);
        step(1'b1, 8'h00, "rd_gpio.dat");

        // GPIO_IN and ID reads
        gpio_in = 8'h5A;
        step(1'b1, 8'h03, "rd_gin.cmd");
        chk("rd_gin.value", tx_byte, 8'h5A);
        step(1'b1, 8'h00, "rd_gin.dat");
        step(1'b1, 8'h0F, "rd_id.cmd");
        chk("rd_id.value", tx_byte, 8'hA5);
        step(1'b1, 8'h00, "rd_id.dat");

        // Write to read-only register, then clear err
        pair(8'h83, 8'h11, "wr_ro");
        chk("wr_ro.err", {7'b0, err}, 8'h01);
        pair(8'h80, 8'h02, "clr_err");
        chk("clr_err.err", {7'b0, err}, 8'h00);

        // Soft reset clears mode/gpio_out and pulses once
        pair(8'h81, 8'h3C, "sr_mode");
        step(1'b1, 8'h82, "sr_gpio.cmd");
        step(1'b1, 8'hAA, "sr_gpio.dat");
        step(1'b1, 8'h80, "sr.cmd");
        step(1'b1, 8'h01, "sr.dat");
        chk("sr.pulse", {7'b0, soft_rst}, 8'h01);
        step(1'b0, 8'h00, "sr.after");
        chk("sr.mode", mode, 8'h00);

        // Timeout with no data byte
        pair(8'h81, 8'h77, "to_setup");
        step(1'b1, 8'h81, "to.cmd");
        for (int i = 0; i < int'(TO); i++) step(1'b0, 8'h00, "to.wait");
        chk("to.busy", {7'b0, busy}, 8'h00);
        chk("to.err", {7'b0, err}, 8'h01);
        chk("to.mode", mode, 8'h77);
        pair(8'h80, 8'h02, "to_clr");

        // Data byte exactly in the expiry cycle wins
        step(1'b1, 8'h81, "exp.cmd");
        for (int i = 0; i < int'(TO) - 1; i++) step(1'b0, 8'h00, "exp.wait");
        step(1'b1, 8'h42, "exp.dat");
        chk("exp.mode", mode, 8'h42);
        chk("exp.err", {7'b0, err}, 8'h00);

        // Reset in the middle of a pair
        step(1'b1, 8'h82, "rstmid.cmd");
        do_reset("rstmid");

        // Randomized streams: mostly legal commands, some illegal, random gaps
        for (int n = 0; n < 400; n++) begin
            logic [7:0] b;
            int gap;
            case ($urandom_range(0, 9))
                0:       b = 8'($urandom);
                1, 2:    b = {1'b1, 3'b000, 4'($urandom_range(0, 3))};
                3:       b = 8'h8F;
                default: b = {1'($urandom_range(0, 1)), 3'b000,
                              ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3))};
            endcase
            if (m_pair) b = 8'($urandom);
            step(1'b1, b, "rand");
            gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                                : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, "rand.gap");
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Command/register stage directly downstream of the SPI slave byte receiver in sbasu3_top. It consumes received bytes as command/data pairs and executes register writes (control, mode, GPIO). It also preloads the response byte that the SPI slave shifts out on miso during the next frame. A timeout counter recovers framing if a data byte never follows a command.

Parameters:
TIMEOUT_CYCLES, 1024, sys_clk cycles allowed between the command byte and its data byte before the pair is abandoned (>=2).
ID_VALUE, 8'hA5, constant returned when the ID register is read.

Ports:
sys_clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_valid  input  1  one-cycle pulse: SPI slave completed a byte
rx_byte  input  8  received byte, valid when rx_valid=1
gpio_in  input  8  external input pins, readable at address 0x3
tx_byte  output  8  response byte for the SPI slave to shift out in its next frame
tx_load  output  1  one-cycle pulse: SPI slave latches tx_byte
gpio_out  output  8  GPIO output register
mode  output  8  mode register
soft_rst  output  1  one-cycle soft-reset pulse to the rest of the design
busy  output  1  1 while in state DATA (command held, data byte awaited)
err  output  1  sticky error flag

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, tx_byte=0x00, tx_load=0, gpio_out=0x00, mode=0x00, soft_rst=0, busy=0, err=0, timeout counter=0. rst has priority over every other event, including mid-pair (DATA state) → IDLE.
- Command byte format: bit7 = write(1)/read(0); bits6:4 must be 000; bits3:0 = address.
- Address map:
  - 0x0 CTRL, write-only bits. bit0=1 issues soft reset. bit1=1 clears err. Reads return {7'b0,err}.
  - 0x1 MODE, read/write.
  - 0x2 GPIO_OUT, read/write.
  - 0x3 GPIO_IN, read-only.
  - 0xF ID, read-only.
  - Any other address is invalid.
- FSM IDLE: rx_valid → latch the command and go to DATA. On the next cycle, tx_load=1 with tx_byte set as follows:
  - Valid read: register value; gpio_in is sampled at this edge.
  - Write or invalid command: 0x00.
- Invalid command (bits6:4≠0, unmapped address, or write to 0x3/0xF): set err and still enter DATA. The data byte is consumed and discarded, which preserves framing.
- FSM DATA: rx_valid → data byte. For a valid write, the register updates at this edge and is visible the next cycle. For reads, the data byte is a dummy and is ignored. Next cycle: tx_load=1, tx_byte={7'b0,err_next}, where err_next is err after this edge. Return to IDLE.
- CTRL write with bit0=1: soft_rst=1 for exactly one cycle. The same edge clears mode, gpio_out and err. bit0 overrides bit1.
- Timeout: the counter clears on entry to DATA and increments each cycle in DATA without rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: go to IDLE, set err, no register write, no tx_load.
  - If rx_valid arrives in the expiry cycle, the byte is accepted as data (rx wins); no timeout error.
- Back-to-back rx_valid on consecutive cycles is legal; each byte is processed in the order received.
- tx_load is never high two cycles in a row unless two bytes arrived on consecutive cycles.
- busy=1 exactly while state=DATA.
- Latency: rx_valid sampled at edge N → outputs change after edge N, visible in cycle N+1.

Test Plan:
- Reset, then send 0x81 followed by 0x3C (write MODE) → mode=0x3C one cycle after the second rx_valid; tx_load pulses twice with tx_byte 0x00 then 0x00; err=0.
- Send 0x82,0xAA (write GPIO_OUT), then 0x02,0x00 (read) → gpio_out=0xAA; the tx_byte loaded after the read command = 0xAA.
- gpio_in=0x5A, send 0x03,0x00 → tx_byte=0x5A. Then 0x0F,0x00 → tx_byte=0xA5.
- Send 0x83,0x11 (write to RO GPIO_IN) → err=1, gpio unchanged, status tx_byte=0x01. Then 0x80,0x02 → err=0.
- Set mode=0x3C and gpio_out=0xAA, then send 0x80,0x01 → soft_rst high exactly one cycle; mode=0x00, gpio_out=0x00.
- Send 0x81, then no byte for TIMEOUT_CYCLES → busy falls, err=1, mode unchanged. Repeat with rx_valid exactly in the expiry cycle → write accepted, err unchanged. Assert rst while in DATA → IDLE with all outputs at reset values.
